scr1_pipe_sleep_ctrl: RTL and testbench

//  Drives sleep_pipe/wake_pipe into the pipeline clock-gating control on WFI.
//  On WFI: drains outstanding memory traffic, requests pipe clock gating, and

---
 rtl/scr1_sleep_pkg.sv | 18 +
 rtl/scr1_pipe_sleep_ctrl.sv | 119 +++++++++++
 tb/tb_scr1_pipe_sleep_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/scr1_sleep_pkg.sv
// Shared types and default timing constants for the pipeline sleep controller.
package scr1_sleep_pkg;

  // WFI sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    SLEEP  = 3'd2,
    WAKE   = 3'd3,
    RESUME = 3'd4
  } type_scr1_sleep_fsm_e;

  // Default cycles allowed for outstanding memory traffic to drain
  localparam int unsigned SCR1_SLEEP_DRAIN_TMO = 64;
  // Default settle cycles after the pipe clock is back before releasing the stall
  localparam int unsigned SCR1_SLEEP_WAKE_DLY  = 2;

endpackage : scr1_sleep_pkg

// File: rtl/scr1_pipe_sleep_ctrl.sv
// WFI sleep controller: drains memory traffic, requests pipe clock gating,
// waits for an interrupt or debug halt request, then re-enables the clock and
// releases the pipeline stall after a settle delay. Runs on the always-on clock.
module scr1_pipe_sleep_ctrl
  import scr1_sleep_pkg::*;
#(
  parameter int unsigned DRAIN_TMO = SCR1_SLEEP_DRAIN_TMO,
  parameter int unsigned WAKE_DLY  = SCR1_SLEEP_WAKE_DLY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wfi_req,
  input  logic pipe_idle,
  input  logic irq_pending,
  input  logic dbg_halt_req,
  input  logic clk_pipe_en,
  output logic sleep_pipe,
  output logic wake_pipe,
  output logic pipe_stall,
  output logic wfi_done,
  output logic wfi_tmo,
  output logic sleeping
);

  localparam int unsigned CNT_W = $clog2(DRAIN_TMO + 1);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TMO - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_DLY - 1);

  type_scr1_sleep_fsm_e state;
  type_scr1_sleep_fsm_e state_next;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_next;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 tmo_next;
  logic                 wake_evt;

  // Either wake source ends the sleep; sampled every cycle
  assign wake_evt = irq_pending | dbg_halt_req;

  // The shared counter saturates instead of wrapping
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // Next-state and counter decisions for the WFI sequence
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    tmo_next   = 1'b0;
    case (state)
      IDLE: begin
        if (wfi_req) begin
          if (wake_evt) begin
            state_next = RESUME;
          end else begin
            state_next = DRAIN;
            cnt_next   = '0;
          end
        end
      end
      DRAIN: begin
        cnt_next = cnt_inc;
        if (wake_evt) begin
          state_next = RESUME;
        end else if (pipe_idle) begin
          state_next = SLEEP;
        end else if (cnt == DRAIN_LAST) begin
          state_next = RESUME;
          tmo_next   = 1'b1;
        end
      end
      SLEEP: begin
        if (wake_evt) begin
          state_next = WAKE;
          cnt_next   = '0;
        end
      end
      WAKE: begin
        if (clk_pipe_en) begin
          if (cnt == WAKE_LAST) begin
            state_next = RESUME;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
      RESUME: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs decoded from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sleep_pipe <= 1'b0;
      wake_pipe  <= 1'b0;
      pipe_stall <= 1'b0;
      wfi_done   <= 1'b0;
      wfi_tmo    <= 1'b0;
      sleeping   <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      sleep_pipe <= (state_next == SLEEP);
      wake_pipe  <= (state_next == WAKE);
      pipe_stall <= (state_next == DRAIN) || (state_next == SLEEP) || (state_next == WAKE);
      wfi_done   <= (state_next == RESUME);
      wfi_tmo    <= tmo_next;
      sleeping   <= (state_next == SLEEP);
    end
  end

endmodule : scr1_pipe_sleep_ctrl

// File: tb/tb_scr1_pipe_sleep_ctrl.sv
// Directed self-checking bench for the WFI sleep controller.
// Output vector order: {sleep_pipe, wake_pipe, pipe_stall, wfi_done, wfi_tmo, sleeping}
module tb_scr1_pipe_sleep_ctrl;

  logic clk;
  logic rst_n;
  logic wfi_req;
  logic pipe_idle;
  logic irq_pending;
  logic dbg_halt_req;
  logic clk_pipe_en;
  logic sleep_pipe;
  logic wake_pipe;
  logic pipe_stall;
  logic wfi_done;
  logic wfi_tmo;
  logic sleeping;

  int total;
  int bad;

  localparam logic [5:0] O_IDLE   = 6'b000000;
  localparam logic [5:0] O_DRAIN  = 6'b001000;
  localparam logic [5:0] O_SLEEP  = 6'b101001;
  localparam logic [5:0] O_WAKE   = 6'b011000;
  localparam logic [5:0] O_DONE   = 6'b000100;
  localparam logic [5:0] O_TMO    = 6'b000110;

  scr1_pipe_sleep_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wfi_req      (wfi_req),
    .pipe_idle    (pipe_idle),
    .irq_pending  (irq_pending),
    .dbg_halt_req (dbg_halt_req),
    .clk_pipe_en  (clk_pipe_en),
    .sleep_pipe   (sleep_pipe),
    .wake_pipe    (wake_pipe),
    .pipe_stall   (pipe_stall),
    .wfi_done     (wfi_done),
    .wfi_tmo      (wfi_tmo),
    .sleeping     (sleeping)
  );

  // Free-running always-on clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive all inputs for the current cycle
  task automatic applyStimulus(input logic wfi, input logic idle, input logic irq,
                               input logic dbg, input logic en);
    wfi_req      = wfi;
    pipe_idle    = idle;
    irq_pending  = irq;
    dbg_halt_req = dbg;
    clk_pipe_en  = en;
  endtask

  // Compare the output vector against the expected one and tally the result
  task automatic checkOutput(input string tag, input logic [5:0] expected);
    logic [5:0] actual;
    actual = {sleep_pipe, wake_pipe, pipe_stall, wfi_done, wfi_tmo, sleeping};
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", tag, actual, expected);
    end
  endtask

  // Advance to the middle of the next cycle
  task automatic nextCycle();
    @(negedge clk);
  endtask

  // Stimulus sequence
  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    applyStimulus(0, 1, 0, 0, 1);
    repeat (3) nextCycle();
    checkOutput("reset", O_IDLE);
    rst_n = 1'b1;
    nextCycle();
    checkOutput("idle_after_reset", O_IDLE);

    // Normal sleep and wake, clock actually gated
    $display("[TB] scenario: sleep and irq wake");
    applyStimulus(1, 1, 0, 0, 1);
    nextCycle();
    checkOutput("s1_drain", O_DRAIN);
    applyStimulus(0, 1, 0, 0, 1);
    nextCycle();
    checkOutput("s1_sleep_at_2", O_SLEEP);
    applyStimulus(0, 1, 0, 0, 0);
    nextCycle();
    checkOutput("s1_sleep_held", O_SLEEP);
    applyStimulus(0, 1, 1, 0, 0);
    nextCycle();
    checkOutput("s1_wake_t1", O_WAKE);
    applyStimulus(0, 1, 0, 0, 0);
    nextCycle();
    checkOutput("s1_wake_t2_no_en", O_WAKE);
    applyStimulus(0, 1, 0, 0, 1);
    nextCycle();
    checkOutput("s1_wake_t3", O_WAKE);
    nextCycle();
    checkOutput("s1_done_t4", O_DONE);
    nextCycle();
    checkOutput("s1_idle", O_IDLE);

    // WFI with wake already pending acts as a NOP
    $display("[TB] scenario: wfi with pending irq");
    applyStimulus(1, 1, 1, 0, 1);
    nextCycle();
    checkOutput("s2_done", O_DONE);
    applyStimulus(0, 1, 0, 0, 1);
    nextCycle();
    checkOutput("s2_idle", O_IDLE);

    // Drain never completes: timeout after DRAIN_TMO cycles
    $display("[TB] scenario: drain timeout");
    applyStimulus(1, 0, 0, 0, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 1; i <= 64; i++) begin
      checkOutput($sformatf("s3_drain_%0d", i), O_DRAIN);
      nextCycle();
    end
    checkOutput("s3_tmo", O_TMO);
    nextCycle();
    checkOutput("s3_idle", O_IDLE);

    // Debug halt request during drain aborts without timeout
    $display("[TB] scenario: dbg halt in drain");
    applyStimulus(1, 0, 0, 0, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("s4_drain_%0d", i), O_DRAIN);
      nextCycle();
    end
    checkOutput("s4_drain_5", O_DRAIN);
    applyStimulus(0, 0, 0, 1, 1);
    nextCycle();
    checkOutput("s4_done", O_DONE);
    applyStimulus(0, 0, 0, 0, 1);
    nextCycle();
    checkOutput("s4_idle", O_IDLE);

    // Wake on the very first sleep cycle, clock never drops
    $display("[TB] scenario: wake in first sleep cycle");
    applyStimulus(1, 1, 0, 0, 1);
    nextCycle();
    checkOutput("s5_drain", O_DRAIN);
    applyStimulus(0, 1, 0, 0, 1);
    nextCycle();
    checkOutput("s5_sleep", O_SLEEP);
    applyStimulus(0, 1, 1, 0, 1);
    nextCycle();
    checkOutput("s5_wake_1", O_WAKE);
    applyStimulus(0, 1, 0, 0, 1);
    nextCycle();
    checkOutput("s5_wake_2", O_WAKE);
    nextCycle();
    checkOutput("s5_done", O_DONE);
    nextCycle();
    checkOutput("s5_idle", O_IDLE);

    // Asynchronous reset while sleeping, then ignored wfi_req during wake
    $display("[TB] scenario: reset in sleep, wfi during wake");
    applyStimulus(1, 1, 0, 0, 1);
    nextCycle();
    applyStimulus(0, 1, 0, 0, 1);
    nextCycle();
    checkOutput("s6_sleep", O_SLEEP);
    #2 rst_n = 1'b0;
    #1 checkOutput("s6_async_reset", O_IDLE);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    checkOutput("s6_idle_post_reset", O_IDLE);
    applyStimulus(1, 1, 0, 0, 1);
    nextCycle();
    applyStimulus(0, 1, 0, 0, 1);
    nextCycle();
    checkOutput("s6_sleep_again", O_SLEEP);
    applyStimulus(0, 1, 1, 0, 1);
    nextCycle();
    checkOutput("s6_wake_1", O_WAKE);
    applyStimulus(1, 1, 0, 0, 1);
    nextCycle();
    checkOutput("s6_wake_2", O_WAKE);
    applyStimulus(0, 1, 0, 0, 1);
    nextCycle();
    checkOutput("s6_done", O_DONE);
    nextCycle();
    checkOutput("s6_idle_1", O_IDLE);
    nextCycle();
    checkOutput("s6_idle_2", O_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_scr1_pipe_sleep_ctrl
